// File: rtl/stack_pkg.sv
// Shared types and constants for the bounded stack-pointer block.
package stack_pkg;
  localparam int STACK_WIDTH = 8;

  typedef enum logic {
    SP_NORMAL = 1'b0,
    SP_FAULT  = 1'b1
  } sp_state_t;
endpackage

// File: rtl/sp_limit_check.sv
// Unsigned window comparator: classifies a candidate against inclusive [lo, hi].
module sp_limit_check
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH
) (
  input  logic [WIDTH-1:0] cand,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic             in_range,
  output logic             above,
  output logic             below
);
  assign above    = cand > hi;
  assign below    = cand < lo;
  assign in_range = !above && !below;
endmodule

// File: rtl/stack_ptr_bounded.sv
// Stack pointer with shadow register, optional modulo wrap, and bounded-mode
// fault FSM with sticky overflow/underflow flags.
module stack_ptr_bounded
  import stack_pkg::*;
#(
  parameter int               WIDTH     = STACK_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               WRAP_EN   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA,
  input  logic             LD,
  input  logic             INCR,
  input  logic             DECR,
  input  logic             SAVE,
  input  logic             RESTORE,
  input  logic             CLR_ERR,
  input  logic [WIDTH-1:0] LIMIT_LO,
  input  logic [WIDTH-1:0] LIMIT_HI,
  output logic [WIDTH-1:0] OUT,
  output logic             EMPTY,
  output logic             FULL,
  output logic             OVF,
  output logic             UNF,
  output logic             FAULT
);
  sp_state_t        state;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] out_nxt;
  logic             step_in, step_above, step_below;
  logic             ld_in, ld_above, ld_below;
  logic             incr_ok, decr_ok;
  logic             ovf_set, unf_set, recover;

  assign step_val = INCR ? OUT + WIDTH'(1) : OUT - WIDTH'(1);
  assign ld_val   = LD ? DATA : shadow;

  sp_limit_check #(.WIDTH(WIDTH)) u_step_chk (
    .cand(step_val), .lo(LIMIT_LO), .hi(LIMIT_HI),
    .in_range(step_in), .above(step_above), .below(step_below)
  );

  sp_limit_check #(.WIDTH(WIDTH)) u_load_chk (
    .cand(ld_val), .lo(LIMIT_LO), .hi(LIMIT_HI),
    .in_range(ld_in), .above(ld_above), .below(ld_below)
  );

  // A step is legal only while it stays on the near side of its limit and does
  // not wrap the WIDTH-bit counter; this reduces to OUT < HI / OUT > LO.
  assign incr_ok = !(&OUT) && (step_in || step_below);
  assign decr_ok = (|OUT) && (step_in || step_above);

  assign FULL  = (WRAP_EN == 0) && (OUT == LIMIT_HI);
  assign EMPTY = (WRAP_EN == 0) && (OUT == LIMIT_LO);
  assign FAULT = (state == SP_FAULT);

  always_comb begin
    out_nxt = OUT;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    recover = 1'b0;
    if (LD || RESTORE) begin
      if ((WRAP_EN != 0) || ld_in) begin
        out_nxt = ld_val;
        recover = 1'b1;
      end else begin
        ovf_set = ld_above;
        unf_set = ld_below;
      end
    end else if (INCR ^ DECR) begin
      if (WRAP_EN != 0) begin
        out_nxt = step_val;
      end else if (state == SP_NORMAL) begin
        if (INCR) begin
          if (incr_ok) out_nxt = step_val;
          else         ovf_set = 1'b1;
        end else begin
          if (decr_ok) out_nxt = step_val;
          else         unf_set = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT    <= RESET_VAL;
      shadow <= RESET_VAL;
      OVF    <= 1'b0;
      UNF    <= 1'b0;
      state  <= SP_NORMAL;
    end else begin
      if (SAVE) shadow <= OUT;
      OUT <= out_nxt;
      if (WRAP_EN != 0) begin
        OVF   <= 1'b0;
        UNF   <= 1'b0;
        state <= SP_NORMAL;
      end else if (ovf_set || unf_set) begin
        // a fresh fault wins over a same-cycle CLR_ERR
        OVF   <= ovf_set || (OVF && !CLR_ERR);
        UNF   <= unf_set || (UNF && !CLR_ERR);
        state <= SP_FAULT;
      end else if (recover || CLR_ERR) begin
        OVF   <= 1'b0;
        UNF   <= 1'b0;
        state <= SP_NORMAL;
      end
    end
  end
endmodule

// File: tb/tb_stack_ptr_bounded.sv
// Drives a wrapping and a bounded instance with shared stimulus and compares both against a reference model.
module tb_stack_ptr_bounded;
  localparam logic [7:0] RV_W = 8'h00;
  localparam logic [7:0] RV_B = 8'h05;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] DATA, LIMIT_LO, LIMIT_HI;
  logic       LD, INCR, DECR, SAVE, RESTORE, CLR_ERR;

  logic [7:0] out_w, out_b;
  logic       empty_w, full_w, ovf_w, unf_w, fault_w;
  logic       empty_b, full_b, ovf_b, unf_b, fault_b;

  int n_vec = 0;
  int n_bad = 0;

  int m_out[2], m_sh[2], m_ovf[2], m_unf[2], m_flt[2];

  always #5 CLK = ~CLK;

  stack_ptr_bounded #(.WIDTH(8), .RESET_VAL(RV_W), .WRAP_EN(1)) dut_w (
    .CLK(CLK), .RST(RST), .DATA(DATA), .LD(LD), .INCR(INCR), .DECR(DECR),
    .SAVE(SAVE), .RESTORE(RESTORE), .CLR_ERR(CLR_ERR),
    .LIMIT_LO(LIMIT_LO), .LIMIT_HI(LIMIT_HI),
    .OUT(out_w), .EMPTY(empty_w), .FULL(full_w), .OVF(ovf_w), .UNF(unf_w), .FAULT(fault_w)
  );

  stack_ptr_bounded #(.WIDTH(8), .RESET_VAL(RV_B), .WRAP_EN(0)) dut_b (
    .CLK(CLK), .RST(RST), .DATA(DATA), .LD(LD), .INCR(INCR), .DECR(DECR),
    .SAVE(SAVE), .RESTORE(RESTORE), .CLR_ERR(CLR_ERR),
    .LIMIT_LO(LIMIT_LO), .LIMIT_HI(LIMIT_HI),
    .OUT(out_b), .EMPTY(empty_b), .FULL(full_b), .OVF(ovf_b), .UNF(unf_b), .FAULT(fault_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out[0] = int'(RV_W); m_sh[0] = int'(RV_W);
    m_out[1] = int'(RV_B); m_sh[1] = int'(RV_B);
    for (int k = 0; k < 2; k++) begin
      m_ovf[k] = 0; m_unf[k] = 0; m_flt[k] = 0;
    end
  endtask

  // One clock of the behavioural rules for instance k (k==0 wraps, k==1 bounded).
  task automatic model_step(input int k);
    int o, nxt, cand, lo, hi;
    bit wrap, ov, un, rec;
    wrap = (k == 0);
    o = m_out[k]; nxt = o; lo = int'(LIMIT_LO); hi = int'(LIMIT_HI);
    ov = 0; un = 0; rec = 0;
    if (LD || RESTORE) begin
      cand = LD ? int'(DATA) : m_sh[k];
      if (wrap || (cand >= lo && cand <= hi)) begin
        nxt = cand; rec = 1;
      end else if (cand > hi) ov = 1;
      else un = 1;
    end else if (INCR != DECR) begin
      if (wrap) nxt = INCR ? (o + 1) % 256 : (o + 255) % 256;
      else if (m_flt[k] == 0) begin
        if (INCR) begin
          if (o >= hi) ov = 1; else nxt = o + 1;
        end else begin
          if (o <= lo) un = 1; else nxt = o - 1;
        end
      end
    end
    if (SAVE) m_sh[k] = o;
    m_out[k] = nxt;
    if (!wrap) begin
      if (ov || un) begin
        m_ovf[k] = (ov || (m_ovf[k] != 0 && !CLR_ERR)) ? 1 : 0;
        m_unf[k] = (un || (m_unf[k] != 0 && !CLR_ERR)) ? 1 : 0;
        m_flt[k] = 1;
      end else if (rec || CLR_ERR) begin
        m_ovf[k] = 0; m_unf[k] = 0; m_flt[k] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " W.out"},   32'(out_w),   32'(m_out[0]));
    check({tag, " W.ovf"},   32'(ovf_w),   32'(m_ovf[0]));
    check({tag, " W.unf"},   32'(unf_w),   32'(m_unf[0]));
    check({tag, " W.fault"}, 32'(fault_w), 32'(m_flt[0]));
    check({tag, " W.empty"}, 32'(empty_w), 32'd0);
    check({tag, " W.full"},  32'(full_w),  32'd0);
    check({tag, " B.out"},   32'(out_b),   32'(m_out[1]));
    check({tag, " B.ovf"},   32'(ovf_b),   32'(m_ovf[1]));
    check({tag, " B.unf"},   32'(unf_b),   32'(m_unf[1]));
    check({tag, " B.fault"}, 32'(fault_b), 32'(m_flt[1]));
    check({tag, " B.empty"}, 32'(empty_b), 32'(m_out[1] == int'(LIMIT_LO)));
    check({tag, " B.full"},  32'(full_b),  32'(m_out[1] == int'(LIMIT_HI)));
  endtask

  task automatic idle();
    LD = 0; INCR = 0; DECR = 0; SAVE = 0; RESTORE = 0; CLR_ERR = 0;
  endtask

  task automatic cycle(input string tag);
    @(posedge CLK);
    model_step(0);
    model_step(1);
    #1;
    check_all(tag);
    idle();
  endtask

  initial begin
    RST = 1'b1; DATA = 8'h00; LIMIT_LO = 8'h10; LIMIT_HI = 8'h13;
    idle();
    model_reset();
    #2 check_all("reset");
    @(negedge CLK); RST = 1'b0;

    // wrap at both ends of the range
    LD = 1; DATA = 8'hFF;  cycle("ld_ff");
    INCR = 1;              cycle("wrap_inc");
    check("wrap_inc lit", 32'(out_w), 32'h00);
    DECR = 1;              cycle("wrap_dec");
    check("wrap_dec lit", 32'(out_w), 32'hFF);
    check("wrap flags", 32'({ovf_w, unf_w, fault_w}), 32'd0);

    // bounded overflow and recovery
    LD = 1; DATA = 8'h12;  cycle("ld_12");
    INCR = 1;              cycle("inc_to_hi");
    check("full at hi", 32'({out_b, full_b}), 32'({8'h13, 1'b1}));
    INCR = 1;              cycle("inc_ovf");
    check("ovf lit", 32'({out_b, ovf_b, fault_b}), 32'({8'h13, 1'b1, 1'b1}));
    DECR = 1;              cycle("dec_in_fault");
    check("dec ignored", 32'(out_b), 32'h13);
    LD = 1; DATA = 8'h11;  cycle("recover");
    check("recover lit", 32'({out_b, ovf_b, fault_b}), 32'({8'h11, 1'b0, 1'b0}));
    LD = 1; DATA = 8'h20;  cycle("ld_above");
    check("ld_above lit", 32'({out_b, ovf_b, fault_b}), 32'({8'h11, 1'b1, 1'b1}));
    DECR = 1; CLR_ERR = 1; cycle("clr_err");
    LD = 1; DATA = 8'h10;  cycle("ld_lo");
    DECR = 1; CLR_ERR = 1; cycle("unf_beats_clr");
    check("unf lit", 32'({unf_b, fault_b}), 32'({1'b1, 1'b1}));
    CLR_ERR = 1;           cycle("clr2");

    // swap and simultaneous inc/dec
    LD = 1; DATA = 8'h10;              cycle("ld_10");
    LD = 1; DATA = 8'h40; SAVE = 1;    cycle("ld_40_save");
    SAVE = 1; RESTORE = 1;             cycle("swap");
    check("swap out", 32'(out_w), 32'h10);
    INCR = 1; DECR = 1;                cycle("inc_dec");
    check("inc_dec hold", 32'(out_w), 32'h10);
    RESTORE = 1;                       cycle("restore_sh");
    check("shadow after swap", 32'(out_w), 32'h40);

    // asynchronous reset between edges
    LIMIT_LO = 8'h30; LIMIT_HI = 8'h33;
    LD = 1; DATA = 8'h33;  cycle("ld_33");
    INCR = 1;              cycle("fault_33");
    check("pre-rst", 32'({out_b, fault_b}), 32'({8'h33, 1'b1}));
    #2 RST = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_rst lit", 32'({out_b, fault_b, ovf_b, unf_b}), 32'({RV_B, 3'b000}));
    @(negedge CLK); RST = 1'b0;
    LD = 1; DATA = 8'h31;  cycle("post_rst");

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        LIMIT_LO = 8'($urandom_range(0, 200));
        LIMIT_HI = 8'(int'(LIMIT_LO) + $urandom_range(0, 40));
      end
      LD      = ($urandom_range(0, 99) < 12);
      RESTORE = ($urandom_range(0, 99) < 10);
      SAVE    = ($urandom_range(0, 99) < 15);
      INCR    = ($urandom_range(0, 99) < 40);
      DECR    = ($urandom_range(0, 99) < 40);
      CLR_ERR = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 3) == 0) DATA = 8'($urandom);
      else begin
        int d;
        d = int'(LIMIT_LO) - 4 + int'($urandom_range(0, 48));
        DATA = 8'((d < 0) ? 0 : ((d > 255) ? 255 : d));
      end
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
